// File: rtl/ebiu_async_master.sv
// Async memory bus initiator: one command at a time, programmable setup/strobe/hold
// timing, optional ARDY wait extension with timeout abort, tristate data bus.
module ebiu_async_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 2,
    parameter int HOLD_CYC     = 1,
    parameter int ARDY_EN      = 0,
    parameter int ARDY_TIMEOUT = 64
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_cmdValid,
    output logic              O_cmdReady,
    input  logic              I_cmdWrite,
    input  logic [ADDR_W-1:0] I_cmdAddr,
    input  logic [DATA_W-1:0] I_cmdWdata,
    output logic              O_rspValid,
    output logic              O_rspErr,
    output logic [DATA_W-1:0] O_rdata,
    output logic              O_busy,
    output logic [ADDR_W-1:0] O_addr,
    output logic              O_bankSelect,
    output logic              O_are,
    output logic              O_awe,
    inout  wire  [DATA_W-1:0] IO_dataBus,
    input  logic              I_ardy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] EXT_MAX     = 8'(ARDY_TIMEOUT);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [7:0]        ext_q;
    logic              write_q;
    logic              err_q;
    logic              drive_q;
    logic              bank_q;
    logic              are_q;
    logic              awe_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic accept;
    logic ardy_ok;
    logic strobe_last;
    logic strobe_ok;
    logic strobe_to;
    logic strobe_end;

    assign accept      = (state_q == IDLE) && I_cmdValid;
    assign ardy_ok     = (ARDY_EN == 0) || I_ardy;
    // Minimum strobe width reached; from here on every edge is an ARDY decision point.
    assign strobe_last = (state_q == STROBE) && (cnt_q >= STROBE_LAST);
    assign strobe_ok   = strobe_last && ardy_ok;
    assign strobe_to   = strobe_last && !ardy_ok && (ext_q >= EXT_MAX);
    assign strobe_end  = strobe_ok || strobe_to;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ext_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            drive_q     <= 1'b0;
            bank_q      <= 1'b0;
            are_q       <= 1'b0;
            awe_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= I_cmdWrite;
                        addr_q  <= I_cmdAddr;
                        wdata_q <= I_cmdWdata;
                        bank_q  <= 1'b1;
                        drive_q <= I_cmdWrite;
                        cnt_q   <= '0;
                        ext_q   <= '0;
                        err_q   <= 1'b0;
                        if (SETUP_CYC == 0) begin
                            state_q <= STROBE;
                            are_q   <= !I_cmdWrite;
                            awe_q   <= I_cmdWrite;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q >= SETUP_LAST) begin
                        state_q <= STROBE;
                        cnt_q   <= '0;
                        are_q   <= !write_q;
                        awe_q   <= write_q;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                STROBE: begin
                    if (strobe_end) begin
                        are_q <= 1'b0;
                        awe_q <= 1'b0;
                        cnt_q <= '0;
                        err_q <= strobe_to;
                        // An aborted read leaves the previous read data in place.
                        if (strobe_ok && !write_q) rdata_q <= IO_dataBus;
                        if (HOLD_CYC == 0) begin
                            state_q     <= IDLE;
                            bank_q      <= 1'b0;
                            drive_q     <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= strobe_to;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (strobe_last) begin
                        ext_q <= ext_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q >= HOLD_LAST) begin
                        state_q     <= IDLE;
                        bank_q      <= 1'b0;
                        drive_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IO_dataBus   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign O_cmdReady   = (state_q == IDLE);
    assign O_busy       = (state_q != IDLE);
    assign O_rspValid   = rsp_valid_q;
    assign O_rspErr     = rsp_err_q;
    assign O_rdata      = rdata_q;
    assign O_addr       = addr_q;
    assign O_bankSelect = bank_q;
    assign O_are        = are_q;
    assign O_awe        = awe_q;

endmodule

// File: tb/tb_ebiu_async_master.sv
// Bench for ebiu_async_master: two instances (default timing, and ARDY-enabled with no
// SETUP and a 2-cycle HOLD) driven by directed and random transactions against a timing model.
module tb_ebiu_async_master;

    localparam int SETUP_C  [2] = '{1, 0};
    localparam int STROBE_C [2] = '{2, 2};
    localparam int HOLD_C   [2] = '{1, 2};
    localparam int AEN_C    [2] = '{0, 1};
    localparam int TO_C     [2] = '{64, 8};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cmd_valid [2];
    logic        cmd_write [2];
    logic [15:0] cmd_addr  [2];
    logic [15:0] cmd_wdata [2];
    logic        ardy      [2];
    logic [15:0] resp_data [2];
    logic        wr_cur    [2];
    logic        ready     [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic        bank      [2];
    logic        are       [2];
    logic        awe       [2];
    logic [15:0] rdata     [2];
    logic [15:0] addr      [2];
    wire  [15:0] bus0;
    wire  [15:0] bus1;

    // Responder drives the bus whenever the master is not supposed to.
    assign bus0 = (wr_cur[0] && bank[0]) ? 16'hzzzz : resp_data[0];
    assign bus1 = (wr_cur[1] && bank[1]) ? 16'hzzzz : resp_data[1];

    ebiu_async_master u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .I_cmdValid(cmd_valid[0]), .O_cmdReady(ready[0]),
        .I_cmdWrite(cmd_write[0]), .I_cmdAddr(cmd_addr[0]), .I_cmdWdata(cmd_wdata[0]),
        .O_rspValid(rsp_valid[0]), .O_rspErr(rsp_err[0]), .O_rdata(rdata[0]), .O_busy(busy[0]),
        .O_addr(addr[0]), .O_bankSelect(bank[0]), .O_are(are[0]), .O_awe(awe[0]),
        .IO_dataBus(bus0), .I_ardy(ardy[0])
    );

    ebiu_async_master #(.SETUP_CYC(0), .STROBE_CYC(2), .HOLD_CYC(2), .ARDY_EN(1), .ARDY_TIMEOUT(8)) u_dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_cmdValid(cmd_valid[1]), .O_cmdReady(ready[1]),
        .I_cmdWrite(cmd_write[1]), .I_cmdAddr(cmd_addr[1]), .I_cmdWdata(cmd_wdata[1]),
        .O_rspValid(rsp_valid[1]), .O_rspErr(rsp_err[1]), .O_rdata(rdata[1]), .O_busy(busy[1]),
        .O_addr(addr[1]), .O_bankSelect(bank[1]), .O_are(are[1]), .O_awe(awe[1]),
        .IO_dataBus(bus1), .I_ardy(ardy[1])
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] rdata_m [2];
    logic [15:0] addr_m  [2];

    function automatic logic [15:0] get_bus(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    task automatic start(input int k, input logic w, input logic [15:0] a, input logic [15:0] wd);
        cmd_valid[k] = 1'b1;
        cmd_write[k] = w;
        cmd_addr[k]  = a;
        cmd_wdata[k] = wd;
    endtask

    // Called just after a negedge with the command presented; returns on the negedge of the rspValid cycle.
    task automatic run_txn(input int k, input logic w, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input int lows, input logic chain,
                           input logic nw, input logic [15:0] na, input logic [15:0] nwd);
        int c, nstr, nbank, lat, le, ext, exp_str, exp_bank;
        logic got, ovl, kind, aerr, berr, first_busy, exp_err;
        logic [15:0] exp_bus;
        c = 1; nstr = 0; nbank = 0; lat = 0; got = 0;
        ovl = 0; kind = 0; aerr = 0; berr = 0; first_busy = 0;
        le = (AEN_C[k] != 0) ? lows : 0;
        wr_cur[k] = w;
        resp_data[k] = ~rd;
        checks++;
        if (ready[k] !== 1'b1) begin
            failures++; $display("FAIL ready_pre k=%0d got=%b exp=1", k, ready[k]);
        end
        @(posedge clk);
        @(negedge clk);
        while (c <= 300) begin
            if (c == 1) begin
                first_busy = busy[k] && bank[k];
                if (chain) start(k, nw, na, nwd);
                else start(k, 1'($urandom), 16'($urandom), 16'($urandom));
                cmd_valid[k] = chain;
            end
            if (rsp_valid[k]) begin
                lat = c; got = 1; break;
            end
            if (bank[k]) nbank++;
            if (are[k] || awe[k]) nstr++;
            if (are[k] && awe[k]) ovl = 1;
            if (w ? are[k] : awe[k]) kind = 1;
            if (bank[k] && addr[k] !== a) aerr = 1;
            exp_bus = (w && bank[k]) ? wd : resp_data[k];
            if (get_bus(k) !== exp_bus) berr = 1;
            if (are[k] || awe[k]) begin
                ardy[k]      = (nstr >= STROBE_C[k] + le);
                resp_data[k] = (nstr >= STROBE_C[k] + le) ? rd : ~rd;
            end else begin
                ardy[k] = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        ardy[k] = 1'b0;
        ext      = (AEN_C[k] != 0) ? ((le < TO_C[k]) ? le : TO_C[k]) : 0;
        exp_err  = (AEN_C[k] != 0) && (le > TO_C[k]);
        exp_str  = STROBE_C[k] + ext;
        exp_bank = SETUP_C[k] + exp_str + HOLD_C[k];
        if (!w && !exp_err) rdata_m[k] = rd;
        addr_m[k] = a;
        checks++;
        if (!got) begin
            failures++; $display("FAIL rsp_timeout k=%0d got=none exp=cycle%0d", k, exp_bank + 1);
        end
        checks++;
        if (lat !== exp_bank + 1) begin
            failures++; $display("FAIL latency k=%0d got=%0d exp=%0d", k, lat, exp_bank + 1);
        end
        checks++;
        if (first_busy !== 1'b1) begin
            failures++; $display("FAIL first_cycle_bank k=%0d got=%b exp=1", k, first_busy);
        end
        checks++;
        if (nbank !== exp_bank) begin
            failures++; $display("FAIL bank_cycles k=%0d got=%0d exp=%0d", k, nbank, exp_bank);
        end
        checks++;
        if (nstr !== exp_str) begin
            failures++; $display("FAIL strobe_cycles k=%0d got=%0d exp=%0d", k, nstr, exp_str);
        end
        checks++;
        if (rsp_err[k] !== exp_err) begin
            failures++; $display("FAIL rsp_err k=%0d got=%b exp=%b", k, rsp_err[k], exp_err);
        end
        checks++;
        if (rdata[k] !== rdata_m[k]) begin
            failures++; $display("FAIL rdata k=%0d got=%h exp=%h", k, rdata[k], rdata_m[k]);
        end
        checks++;
        if (ready[k] !== 1'b1 || busy[k] !== 1'b0 || bank[k] !== 1'b0) begin
            failures++; $display("FAIL rsp_idle k=%0d got=rdy%b busy%b bank%b exp=rdy1 busy0 bank0", k, ready[k], busy[k], bank[k]);
        end
        checks++;
        if ({ovl, kind, aerr, berr} !== 4'b0) begin
            failures++; $display("FAIL bus_protocol k=%0d got=ovl%b kind%b addr%b data%b exp=0000", k, ovl, kind, aerr, berr);
        end
    endtask

    task automatic idle_check(input int k);
        @(negedge clk);
        checks++;
        if (rsp_valid[k] !== 1'b0 || busy[k] !== 1'b0 || bank[k] !== 1'b0 || are[k] !== 1'b0 || awe[k] !== 1'b0) begin
            failures++; $display("FAIL idle_state k=%0d got=rsp%b busy%b bank%b are%b awe%b exp=all0", k, rsp_valid[k], busy[k], bank[k], are[k], awe[k]);
        end
        checks++;
        if (addr[k] !== addr_m[k] || get_bus(k) !== resp_data[k]) begin
            failures++; $display("FAIL idle_addr_bus k=%0d got=%h/%h exp=%h/%h", k, addr[k], get_bus(k), addr_m[k], resp_data[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                failures++; $display("FAIL reset_ready k=%0d got=rdy%b busy%b exp=rdy1 busy0", k, ready[k], busy[k]);
            end
            checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_err[k] !== 1'b0 || bank[k] !== 1'b0 || are[k] !== 1'b0 || awe[k] !== 1'b0) begin
                failures++; $display("FAIL reset_ctl k=%0d got=%b%b%b%b%b exp=00000", k, rsp_valid[k], rsp_err[k], bank[k], are[k], awe[k]);
            end
            checks++;
            if (rdata[k] !== 16'h0 || addr[k] !== 16'h0 || get_bus(k) !== resp_data[k]) begin
                failures++; $display("FAIL reset_data k=%0d got=rd%h ad%h bus%h exp=0/0/%h", k, rdata[k], addr[k], get_bus(k), resp_data[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        start(0, 1'b1, 16'h0002, 16'h0001);
        run_txn(0, 1'b1, 16'h0002, 16'h0001, 16'h0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(0);
    endtask

    task automatic test_read_basic();
        start(0, 1'b0, 16'h0001, 16'h0);
        run_txn(0, 1'b0, 16'h0001, 16'h0, 16'h2030, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd;
        for (int k = 0; k < 2; k++) begin
            wd = 16'($urandom) | 16'h0100;
            start(k, 1'b1, 16'h0006, wd);
            run_txn(k, 1'b1, 16'h0006, wd, 16'h0, 0, 1'b1, 1'b0, 16'h0004, 16'h0);
            run_txn(k, 1'b0, 16'h0004, 16'h0, 16'($urandom), 1, 1'b0, 1'b0, 16'h0, 16'h0);
            idle_check(k);
        end
    endtask

    task automatic test_ardy_ext();
        start(1, 1'b0, 16'h0010, 16'h0);
        run_txn(1, 1'b0, 16'h0010, 16'h0, 16'h5A3C, 3, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(1);
        start(1, 1'b1, 16'h0011, 16'hBEEF);
        run_txn(1, 1'b1, 16'h0011, 16'hBEEF, 16'h0, 2, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(1);
    endtask

    task automatic test_ardy_timeout();
        start(1, 1'b0, 16'h0020, 16'h0);
        run_txn(1, 1'b0, 16'h0020, 16'h0, 16'h1234, 100, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(1);
        // Exactly TIMEOUT low edges then ARDY high still completes normally.
        start(1, 1'b0, 16'h0021, 16'h0);
        run_txn(1, 1'b0, 16'h0021, 16'h0, 16'h4321, 8, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(1);
        start(1, 1'b1, 16'h0022, 16'h7777);
        run_txn(1, 1'b1, 16'h0022, 16'h7777, 16'h0, 9, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(1);
    endtask

    task automatic test_random();
        int k, lows;
        logic pend, w, ch, nw;
        logic [15:0] a, wd, rd, na, nwd;
        pend = 0; k = 0; w = 0; a = 0; wd = 0;
        for (int i = 0; i < 30; i++) begin
            if (!pend) begin
                k = int'($urandom_range(0, 1));
                w = 1'($urandom); a = 16'($urandom); wd = 16'($urandom);
                start(k, w, a, wd);
            end
            lows = int'($urandom_range(0, 11));
            rd   = 16'($urandom);
            ch   = ($urandom_range(0, 2) == 0) && (i < 29);
            nw = 1'($urandom); na = 16'($urandom); nwd = 16'($urandom);
            run_txn(k, w, a, wd, rd, lows, ch, nw, na, nwd);
            if (ch) begin
                w = nw; a = na; wd = nwd; pend = 1;
            end else begin
                pend = 0; idle_check(k);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen, bad;
        logic [15:0] wd;
        seen = 0; bad = 0;
        wd = 16'($urandom) | 16'h8001;
        resp_data[0] = 16'h0;
        wr_cur[0] = 1'b1;
        start(0, 1'b1, 16'h0033, wd);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (awe[0]) begin
                seen = 1; break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL mid_awe_seen got=0 exp=1");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (awe[0] !== 1'b0 || bank[0] !== 1'b0 || bus0 !== 16'h0) begin
            failures++; $display("FAIL mid_reset_drop got=awe%b bank%b bus%h exp=0/0/0000", awe[0], bank[0], bus0);
        end
        checks++;
        if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state got=rdy%b busy%b rsp%b exp=1/0/0", ready[0], busy[0], rsp_valid[0]);
        end
        rdata_m[0] = 16'h0; rdata_m[1] = 16'h0;
        addr_m[0] = 16'h0; addr_m[1] = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0 || ready[0] !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL post_reset_quiet got=rsp_or_notready exp=idle");
        end
        start(0, 1'b0, 16'h0044, 16'h0);
        run_txn(0, 1'b0, 16'h0044, 16'h0, 16'hC0DE, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle_check(0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_addr[k] = 16'h0; cmd_wdata[k] = 16'h0;
            ardy[k] = 1'b0; resp_data[k] = 16'h0; wr_cur[k] = 1'b0;
            rdata_m[k] = 16'h0; addr_m[k] = 16'h0;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_ardy_ext();
        test_ardy_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
